// File: rtl/ascon_pkg.sv
// Shared types and sizes for the ASCON decrypt sequencer.
// Holds the state enum, block/tag widths and a block-select helper.
package ascon_pkg;

  localparam int N_BLOCKS = 23;
  localparam int BLOCK_W  = 64;
  localparam int TAG_W    = 128;
  localparam int CNT_W    = 5;
  localparam int TEXT_W   = N_BLOCKS * BLOCK_W;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WAIT_INIT,
    AD,
    WAIT_AD,
    AD_END,
    LOAD,
    SEND,
    CAPTURE,
    NEXT,
    FINAL,
    COMPARE,
    DONE
  } state_t;

  // Block 0 is the most significant 64-bit slice.
  function automatic logic [BLOCK_W-1:0] get_block(
    input logic [TEXT_W-1:0] t,
    input logic [CNT_W-1:0]  k
  );
    return t[(N_BLOCKS-1-int'(k))*BLOCK_W +: BLOCK_W];
  endfunction

endpackage

// File: rtl/ascon_decrypt_fsm_if.sv
// Handshake bundle between the sequencer and the external ASCON core.
// master = sequencer (drives requests), slave = core (drives results).
interface ascon_decrypt_fsm_if;
  import ascon_pkg::*;

  logic               init_o;
  logic               associate_data_o;
  logic               finalisation_o;
  logic               data_valid_o;
  logic [BLOCK_W-1:0] data_o;
  logic [TAG_W-1:0]   key_o;
  logic [TAG_W-1:0]   nonce_o;

  logic               end_initialisation_i;
  logic               end_associate_i;
  logic               plain_valid_i;
  logic               end_plain_i;
  logic               end_tag_i;
  logic [BLOCK_W-1:0] plain_i;
  logic [TAG_W-1:0]   tag_i;

  modport master (
    output init_o, associate_data_o, finalisation_o,
    output data_valid_o, data_o, key_o, nonce_o,
    input  end_initialisation_i, end_associate_i,
    input  plain_valid_i, end_plain_i, end_tag_i,
    input  plain_i, tag_i
  );

  modport slave (
    input  init_o, associate_data_o, finalisation_o,
    input  data_valid_o, data_o, key_o, nonce_o,
    output end_initialisation_i, end_associate_i,
    output plain_valid_i, end_plain_i, end_tag_i,
    output plain_i, tag_i
  );

endinterface

// File: rtl/ascon_decrypt_fsm_compteur.sv
// Generic up-counter with synchronous clear and enable.
// i_clk/i_rst_n (sync, active-low), i_clr, i_en -> o_cnt.
module compteur_Nbits #(
  parameter int N_bits = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [N_bits-1:0] o_cnt
);

  logic [N_bits-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ascon_decrypt_fsm.sv
// Sequences one ASCON decryption over an external core, buffers plaintext.
// Ports: clock_i/reset_i/start_i, cipher/key/nonce/da/tag_ref in, core bus, plain_text_o/tag_ok_o/done_o/busy_o.
module ascon_decrypt_fsm
  import ascon_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [TEXT_W-1:0]   cipher_i,
  input  logic [TAG_W-1:0]    key_i,
  input  logic [TAG_W-1:0]    nonce_i,
  input  logic [BLOCK_W-1:0]  da_i,
  input  logic [TAG_W-1:0]    tag_ref_i,
  ascon_decrypt_fsm_if.master core,
  output logic [TEXT_W-1:0]   plain_text_o,
  output logic                tag_ok_o,
  output logic                done_o,
  output logic                busy_o
);

  state_t r_state, w_next;

  logic [CNT_W-1:0]   w_k, w_k_nxt;
  logic               w_clr, w_inc;
  logic               w_init, w_ad, w_fin, w_dv, w_eq;
  logic [BLOCK_W-1:0] w_data;
  logic [TEXT_W-1:0]  w_buf_flat;

  logic [BLOCK_W-1:0] r_buf [N_BLOCKS];
  logic [TAG_W-1:0]   r_tag;
  logic               r_init, r_ad, r_fin, r_dv;
  logic [BLOCK_W-1:0] r_data;
  logic [TAG_W-1:0]   r_key, r_nonce;
  logic [TEXT_W-1:0]  r_plain;
  logic               r_tag_ok, r_done, r_busy;

  compteur_Nbits #(.N_bits(CNT_W)) u_cnt (
    .i_clk   (clock_i),
    .i_rst_n (reset_i),
    .i_clr   (w_clr),
    .i_en    (w_inc),
    .o_cnt   (w_k)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_inc  = 1'b0;
    unique case (r_state)
      IDLE:      if (start_i) w_next = INIT;
      INIT:      w_next = WAIT_INIT;
      WAIT_INIT: if (core.end_initialisation_i) w_next = AD;
      AD:        w_next = WAIT_AD;
      WAIT_AD:   if (core.end_associate_i) w_next = AD_END;
      AD_END:    w_next = LOAD;
      LOAD: begin
        w_clr  = 1'b1;
        w_next = SEND;
      end
      SEND:      if (core.plain_valid_i) w_next = CAPTURE;
      CAPTURE:   if (core.end_plain_i) w_next = NEXT;
      NEXT: begin
        w_inc  = 1'b1;
        w_next = (w_k == CNT_W'(N_BLOCKS-2)) ? FINAL : SEND;
      end
      FINAL:     if (core.end_tag_i) w_next = COMPARE;
      COMPARE:   w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase

    w_k_nxt = w_clr ? '0 : (w_inc ? w_k + 1'b1 : w_k);

    w_init = (w_next == INIT) || (w_next == AD);
    w_ad   = (w_next == AD);
    w_fin  = (w_next == FINAL);
    w_dv   = (w_next == AD) || (w_next == SEND) || (w_next == FINAL);
    w_data = '0;
    if (w_next == AD)    w_data = da_i;
    if (w_next == SEND)  w_data = get_block(cipher_i, w_k_nxt);
    if (w_next == FINAL) w_data = cipher_i[BLOCK_W-1:0];
  end

  always_comb begin
    w_buf_flat = '0;
    for (int i = 0; i < N_BLOCKS; i++)
      w_buf_flat[(N_BLOCKS-1-i)*BLOCK_W +: BLOCK_W] = r_buf[i];
  end

  // Full-width compare, no early exit.
  assign w_eq = (r_tag == tag_ref_i);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int i = 0; i < N_BLOCKS; i++) r_buf[i] <= '0;
      r_tag    <= '0;
      r_init   <= 1'b0;
      r_ad     <= 1'b0;
      r_fin    <= 1'b0;
      r_dv     <= 1'b0;
      r_data   <= '0;
      r_key    <= '0;
      r_nonce  <= '0;
      r_plain  <= '0;
      r_tag_ok <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_init  <= w_init;
      r_ad    <= w_ad;
      r_fin   <= w_fin;
      r_dv    <= w_dv;
      r_data  <= w_data;
      r_key   <= key_i;
      r_nonce <= nonce_i;
      r_busy  <= (w_next != IDLE);
      r_done  <= (r_state == COMPARE);
      if (r_state == SEND && core.plain_valid_i)
        r_buf[w_k] <= core.plain_i;
      if (r_state == FINAL && core.plain_valid_i)
        r_buf[N_BLOCKS-1] <= core.plain_i;
      if (r_state == FINAL && core.end_tag_i)
        r_tag <= core.tag_i;
      // Plaintext is only released once the tag has been checked.
      if (r_state == IDLE && start_i) begin
        r_plain  <= '0;
        r_tag_ok <= 1'b0;
      end else if (r_state == COMPARE) begin
        r_tag_ok <= w_eq;
        r_plain  <= w_eq ? w_buf_flat : '0;
      end
    end
  end

  assign core.init_o           = r_init;
  assign core.associate_data_o = r_ad;
  assign core.finalisation_o   = r_fin;
  assign core.data_valid_o     = r_dv;
  assign core.data_o           = r_data;
  assign core.key_o            = r_key;
  assign core.nonce_o          = r_nonce;

  assign plain_text_o = r_plain;
  assign tag_ok_o     = r_tag_ok;
  assign done_o       = r_done;
  assign busy_o       = r_busy;

endmodule
